reg_load_arbiter: RTL and testbench

Round-robin arbiter that shares the load port of one WIDTH-bit pipeline register among NREQ requesters in the processor datapath. Each cycle it picks at most one requester, drives that requester's data and a load enable to the register, and returns a one-cycle grant. A requester can lock the register for a bounded burst of back-to-back loads.

---
 rtl/reg_load_arbiter.sv | 66 ++++++
 tb/tb_reg_load_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin arbiter with bounded lock bursts driving one shared register load port
module reg_load_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter int LOCK_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       gnt,
    output logic                  ld_en,
    output logic [WIDTH-1:0]      ld_data,
    output logic [1:0]            owner,
    output logic                  busy
);
    typedef enum logic {ARB, LOCKED} state_t;
    state_t state, state_n;
    logic [1:0] ptr, ptr_n, w, sel;
    logic [7:0] cnt, cnt_n;
    logic found, hold, go;
    logic [NREQ-1:0] gnt_n;
    logic [WIDTH-1:0] slice [NREQ];
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice[g] = data[g*WIDTH +: WIDTH];
    end
    assign busy = state == LOCKED;
    always_comb begin
        w = ptr;
        found = 1'b0;
        for (int i = NREQ-1; i >= 0; i--)
            if (req[ptr + 2'(i)]) begin
                w = ptr + 2'(i);
                found = 1'b1;
            end
        hold = state == LOCKED && req[owner] && lock[owner] && cnt < 8'(LOCK_MAX);
        go = hold || found;
        sel = hold ? owner : w;
        gnt_n = go ? {{(NREQ-1){1'b0}}, 1'b1} << sel : '0;
        ptr_n = hold ? ptr : found ? w + 2'd1 : ptr;
        state_n = (hold || (found && lock[w])) ? LOCKED : ARB;
        cnt_n = hold ? cnt + 8'd1 : (found && lock[w]) ? 8'd1 : cnt;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB;
            ptr <= '0;
            cnt <= '0;
            gnt <= '0;
            ld_en <= 1'b0;
            ld_data <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
            gnt <= gnt_n;
            ld_en <= go;
            if (go) begin
                ld_data <= slice[sel];
                owner <= sel;
            end
        end
    end
endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter: scoreboard bench for reg_load_arbiter with directed vectors
module tb_reg_load_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic [3:0] req, lock;
    logic [31:0] data;
    logic [3:0] gnt;
    logic ld_en;
    logic [7:0] ld_data;
    logic [1:0] owner;
    logic busy;
    int total = 0;
    int bad = 0;
    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] o;
        logic b;
    } exp_t;
    exp_t q[$];
    reg_load_arbiter #(.NREQ(4), .WIDTH(8), .LOCK_MAX(8)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .data(data),
        .gnt(gnt), .ld_en(ld_en), .ld_data(ld_data), .owner(owner), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    task automatic push(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o, input logic b, input int n);
        for (int i = 0; i < n; i++) q.push_back('{g: g, d: d, o: o, b: b});
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (ld_en || gnt != 4'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_grant", {28'b0, gnt}, 32'b0);
            end else begin
                e = q.pop_front();
                chk("gnt", {28'b0, gnt}, {28'b0, e.g});
                chk("ld_en", {31'b0, ld_en}, 32'd1);
                chk("ld_data", {24'b0, ld_data}, {24'b0, e.d});
                chk("owner", {30'b0, owner}, {30'b0, e.o});
                chk("busy", {31'b0, busy}, {31'b0, e.b});
            end
        end else if (busy) begin
            chk("idle_busy", {31'b0, busy}, 32'b0);
        end
    end
    initial begin
        reset = 1'b0;
        req = '0;
        lock = '0;
        data = '0;
        step(3);
        chk("rst_gnt", {28'b0, gnt}, 32'b0);
        chk("rst_ld_en", {31'b0, ld_en}, 32'b0);
        chk("rst_ld_data", {24'b0, ld_data}, 32'b0);
        chk("rst_owner", {30'b0, owner}, 32'b0);
        chk("rst_busy", {31'b0, busy}, 32'b0);
        reset = 1'b1;
        step(1);
        // single request, unselected slices undriven
        data = {8'hxx, 8'hxx, 8'hxx, 8'hA5};
        req = 4'b0001;
        push(4'b0001, 8'hA5, 2'd0, 1'b0, 1);
        step(1);
        req = 4'b0000;
        step(1);
        chk("single_idle_gnt", {28'b0, gnt}, 32'b0);
        chk("single_idle_ld_en", {31'b0, ld_en}, 32'b0);
        // simultaneous 1010, ptr=1
        data = {8'h43, 8'h32, 8'h21, 8'h10};
        req = 4'b1010;
        push(4'b0010, 8'h21, 2'd1, 1'b0, 1);
        push(4'b1000, 8'h43, 2'd3, 1'b0, 1);
        push(4'b0010, 8'h21, 2'd1, 1'b0, 1);
        push(4'b1000, 8'h43, 2'd3, 1'b0, 1);
        step(4);
        req = 4'b0000;
        step(1);
        // full load, ptr=0
        data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        push(4'b0001, 8'h10, 2'd0, 1'b0, 1);
        push(4'b0010, 8'h11, 2'd1, 1'b0, 1);
        push(4'b0100, 8'h12, 2'd2, 1'b0, 1);
        push(4'b1000, 8'h13, 2'd3, 1'b0, 1);
        push(4'b0001, 8'h10, 2'd0, 1'b0, 1);
        step(5);
        req = 4'b0000;
        step(1);
        // burst cap: move ptr to 2 then lock requester 2
        req = 4'b0010;
        push(4'b0010, 8'h11, 2'd1, 1'b0, 1);
        step(1);
        req = 4'b0101;
        lock = 4'b0100;
        push(4'b0100, 8'h12, 2'd2, 1'b1, 8);
        push(4'b0001, 8'h10, 2'd0, 1'b0, 1);
        push(4'b0100, 8'h12, 2'd2, 1'b1, 1);
        step(10);
        req = 4'b0000;
        lock = 4'b0000;
        step(1);
        chk("burst_end_busy", {31'b0, busy}, 32'b0);
        // early release: ptr=3, grant 0 to reach ptr=1
        req = 4'b0001;
        push(4'b0001, 8'h10, 2'd0, 1'b0, 1);
        step(1);
        req = 4'b0011;
        lock = 4'b0010;
        push(4'b0010, 8'h11, 2'd1, 1'b1, 3);
        step(3);
        lock = 4'b0000;
        push(4'b0001, 8'h10, 2'd0, 1'b0, 1);
        step(1);
        req = 4'b0000;
        step(1);
        // reset mid-burst: ptr=1
        req = 4'b0010;
        lock = 4'b0010;
        push(4'b0010, 8'h11, 2'd1, 1'b1, 4);
        step(4);
        reset = 1'b0;
        req = 4'b1111;
        lock = 4'b0000;
        step(1);
        chk("midrst_gnt", {28'b0, gnt}, 32'b0);
        chk("midrst_ld_en", {31'b0, ld_en}, 32'b0);
        chk("midrst_ld_data", {24'b0, ld_data}, 32'b0);
        chk("midrst_owner", {30'b0, owner}, 32'b0);
        chk("midrst_busy", {31'b0, busy}, 32'b0);
        reset = 1'b1;
        push(4'b0001, 8'h10, 2'd0, 1'b0, 1);
        step(1);
        req = 4'b0000;
        step(3);
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
